gs_iter_controller: RTL

Sequencing controller for the Goldschmidt divider datapath. It accepts a normalised numerator/denominator pair and issues the N*F and D*F products of each iteration to the shared 3-stage pipelined multiplier, computing F = 2 - D. It collects the pipelined products, updates N and D, counts iterations, and presents the quotient with a done pulse. It sits between the divider front end (normalisation) and the multiplier input FIFO/pipeline.

---
 rtl/gs_iter_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gs_iter_controller.sv
// Goldschmidt divider sequencer: issues N*F and D*F to a shared pipelined multiplier,
// folds the truncated products back into N/D and reports the quotient with a done pulse.
//   state   | meaning
//   IDLE    | waiting for start, operands latched on start
//   ISSUE_N | N*F issued (tag 0)
//   ISSUE_D | D*F issued (tag 1), early N product accepted
//   WAIT    | collecting products; D product closes the iteration
//   FIN     | done pulse, q_out valid
module gs_iter_controller #(
  parameter int WIDTH = 32,
  parameter int ITERS = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   n_in,
  input  logic [WIDTH-1:0]   d_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   q_out,
  output logic               mul_valid,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_tag,
  input  logic               res_valid,
  input  logic               res_tag,
  input  logic [2*WIDTH-1:0] res_data
);

  typedef enum logic [2:0] {IDLE, ISSUE_N, ISSUE_D, WAIT, FIN} state_t;

  localparam logic [WIDTH-1:0] TWO = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] n_reg, d_reg, f_reg, n_nxt, d_nxt, f_nxt;
  logic [WIDTH-1:0] q_nxt, mul_a_nxt, mul_b_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_flag, err_flag_nxt;
  logic [WIDTH-1:0] res_scaled;
  logic             d_legal, last_iter;
  logic             unused_bits;

  // Q4.(2W-4) product back to Q2.(W-2) by truncation
  assign res_scaled  = res_data[2*WIDTH-3 -: WIDTH];
  assign unused_bits = ^{res_data[2*WIDTH-1:2*WIDTH-2], res_data[WIDTH-3:0]};
  assign d_legal     = (d_in[WIDTH-1:WIDTH-2] == 2'b00) && d_in[WIDTH-3];
  assign last_iter   = (cnt == CNT_W'(ITERS-1));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      n_reg    <= '0;
      d_reg    <= '0;
      f_reg    <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      q_out    <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      state    <= state_nxt;
      n_reg    <= n_nxt;
      d_reg    <= d_nxt;
      f_reg    <= f_nxt;
      cnt      <= cnt_nxt;
      err_flag <= err_flag_nxt;
      q_out    <= q_nxt;
      mul_a    <= mul_a_nxt;
      mul_b    <= mul_b_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    n_nxt        = n_reg;
    d_nxt        = d_reg;
    f_nxt        = f_reg;
    cnt_nxt      = cnt;
    err_flag_nxt = err_flag;
    q_nxt        = q_out;
    mul_a_nxt    = mul_a;
    mul_b_nxt    = mul_b;
    busy         = (state != IDLE);
    done         = 1'b0;
    err          = 1'b0;
    mul_valid    = 1'b0;
    mul_tag      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          n_nxt   = n_in;
          d_nxt   = d_in;
          cnt_nxt = '0;
          if (!d_legal) begin
            err_flag_nxt = 1'b1;
            q_nxt        = '0;
            state_nxt    = FIN;
          end else begin
            err_flag_nxt = 1'b0;
            f_nxt        = TWO - d_in;
            mul_a_nxt    = n_in;
            mul_b_nxt    = TWO - d_in;
            state_nxt    = ISSUE_N;
          end
        end
      end
      ISSUE_N: begin
        mul_valid = 1'b1;
        mul_a_nxt = d_reg;
        mul_b_nxt = f_reg;
        state_nxt = ISSUE_D;
      end
      ISSUE_D: begin
        mul_valid = 1'b1;
        mul_tag   = 1'b1;
        // a single-cycle multiplier returns the N product here
        if (res_valid && !res_tag) n_nxt = res_scaled;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (res_valid && !res_tag) begin
          n_nxt = res_scaled;
        end else if (res_valid && res_tag) begin
          d_nxt = res_scaled;
          if (last_iter) begin
            q_nxt     = n_reg;
            state_nxt = FIN;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            f_nxt     = TWO - res_scaled;
            mul_a_nxt = n_reg;
            mul_b_nxt = TWO - res_scaled;
            state_nxt = ISSUE_N;
          end
        end
      end
      FIN: begin
        done      = 1'b1;
        err       = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
